pipe_regwall_chain: RTL and testbench
=====================================

Name: pipe_regwall_chain

Overview:
- Parametrised chain of pipeline register walls for the CPU datapath. Each stage has a valid bit and a DATA_W payload.
- Per-stage stall (hold plus bubble insertion) and per-stage flush generalise the fixed two-hazard/one-flush wall to any STAGES depth.
- Every stage's contents are exposed as taps so the forwarding and hazard logic can read them.
- Sits between fetch/decode/execute/memory/writeback; the stage count is set per instance.

Parameters:
- DATA_W, 32, payload width per stage (1..256).
- STAGES, 4, number of register stages (2..8); stage 0 is nearest the input.

Ports:
- clock  in  1  core clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-high; sampled on the falling edge.
- enable  in  1  global wall enable; low = every stage holds.
- in_valid  in  1  stage-0 input valid.
- in_data  in  DATA_W  stage-0 input payload.
- in_ready  out  1  combinational; = enable & ~(|stall); upstream may advance its PC only when high.
- stall  in  STAGES  stall[k]: hold stages 0..k, insert bubble into k+1.
- flush  in  STAGES  flush[k]: stage k loads a bubble instead of advancing.
- tap_valid  out  STAGES  valid bit of each stage; bit k = stage k.
- tap_data  out  STAGES*DATA_W  payloads; slice [k*DATA_W +: DATA_W] = stage k.
- out_valid  out  1  = tap_valid[STAGES-1].
- out_data  out  DATA_W  = stage STAGES-1 payload.
- stall_cycles  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset (falling edge, reset=1): all valid=0, all data=0, stall_cycles=0. Reset overrides enable, stall and flush. Reset in mid-stream discards all in-flight entries.
- enable=0 and reset=0: every stage holds; flush and stall are ignored; the counter holds.
- Bubble: valid=0 and data=0. Payload is always zeroed with valid so the decode of a bubble is a NOP.
- Let s = highest index k with stall[k]=1; s is undefined when stall==0.
- Per-stage next state when enable=1, in priority order:
  1. k <= s: hold (stall beats flush, as the current wall does).
  2. k == s+1: load bubble.
  3. flush[k]=1: load bubble.
  4. Otherwise advance: stage 0 loads {in_valid, in_data}; stage k loads stage k-1.
- When stall==0, rule 1 does not apply to any stage; no rule-2 bubble is inserted.
- If s == STAGES-1, no stage receives the rule-2 bubble; the whole chain holds.
- Lower stall bits below s are redundant; the result is identical to stall[s] alone.
- Flush of stage k has no effect on stages > k in the same edge; they advance from their own predecessors.
- Latency: an entry accepted at edge n (in_ready=1) appears on out_* after edge n+STAGES-1, provided there are no stalls or flushes. Throughput is 1 per cycle.
- Outputs are direct register values; no combinational path from in_* to tap_* or out_*.
- in_ready depends only on enable and stall; never on valid bits.
- in_valid=0 with in_ready=1 inserts a bubble at stage 0.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cycles is a 16-bit counter. It increments on each falling edge with enable=1, reset=0 and |stall=1. It saturates at 16'hFFFF (no wrap) and clears only on reset.
- Undefined: no counter logic; stall_cycles is tied to 16'h0000. The port still exists so instances do not change.

Test Plan:
- Reset/flow (STAGES=4, DATA_W=32): hold reset 2 edges, then all taps are 0. Feed 0x11,0x22,0x33 with in_valid=1 on consecutive edges -> out_data shows 0x11 on the 4th edge, then 0x22 and 0x33 on following edges; out_valid=1 for exactly 3 edges.
- Stall insertion: pipeline full of A(s0),B(s1),C(s2),D(s3); assert stall=4'b0010 for one edge -> s0=A, s1=B, s2=bubble (valid 0, data 0), s3=C. in_ready=0 during that cycle.
- Stall vs flush: stall=4'b0001 and flush=4'b0011 on the same edge -> s0 holds its value, s1 is a bubble, s2/s3 advance.
- Full-depth stall: stall[3]=1 for 3 edges -> every tap unchanged for all 3 edges, no bubble appears. With PIPE_STALL_CNT_EN, stall_cycles=3.
- Enable/reset interaction: enable=0 with flush=4'b1111 -> nothing changes. Then reset=1 with enable=0 -> all valid=0 and stall_cycles=0 on that edge.
- Counter saturation (PIPE_STALL_CNT_EN): force the counter to 16'hFFFE, then stall for 3 edges -> reads 16'hFFFF and stays there. Without the macro it reads 0 throughout.

Source files
------------

// File: rtl/pipe_regwall_chain.sv
// Parametrised chain of falling-edge pipeline register walls with per-stage stall/flush and taps.
// Optional macro PIPE_STALL_CNT_EN adds a saturating stall-cycle counter on stall_cycles.
module pipe_regwall_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall,
    input  logic [STAGES-1:0]          flush,
    output logic [STAGES-1:0]          tap_valid,
    output logic [STAGES*DATA_W-1:0]   tap_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [15:0]                stall_cycles
);

    logic [STAGES-1:0]             stageValid;
    logic [STAGES-1:0][DATA_W-1:0] stageData;
    logic [STAGES-1:0]             nextValid;
    logic [STAGES-1:0][DATA_W-1:0] nextData;
    logic [STAGES-1:0]             holdStage;
    logic [STAGES-1:0]             bubbleStage;

    // A stage holds when any stall bit at or above it is set; the stage just
    // above the highest stall bit receives the bubble.
    always_comb begin
        logic anyAbove;
        holdStage   = '0;
        bubbleStage = '0;
        anyAbove    = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            anyAbove     = anyAbove | stall[k];
            holdStage[k] = anyAbove;
        end
        for (int k = 1; k < STAGES; k++) begin
            bubbleStage[k] = stall[k-1] & ~holdStage[k];
        end
    end

    always_comb begin
        nextValid = stageValid;
        nextData  = stageData;
        if (holdStage[0]) begin
            nextValid[0] = stageValid[0];
            nextData[0]  = stageData[0];
        end else if (flush[0]) begin
            nextValid[0] = 1'b0;
            nextData[0]  = '0;
        end else begin
            nextValid[0] = in_valid;
            nextData[0]  = in_valid ? in_data : '0;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (holdStage[k]) begin
                nextValid[k] = stageValid[k];
                nextData[k]  = stageData[k];
            end else if (bubbleStage[k] || flush[k]) begin
                nextValid[k] = 1'b0;
                nextData[k]  = '0;
            end else begin
                nextValid[k] = stageValid[k-1];
                nextData[k]  = stageData[k-1];
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            stageValid <= '0;
            stageData  <= '0;
        end else if (enable) begin
            stageValid <= nextValid;
            stageData  <= nextData;
        end
    end

    assign in_ready  = enable & ~(|stall);
    assign tap_valid = stageValid;
    assign tap_data  = stageData;
    assign out_valid = stageValid[STAGES-1];
    assign out_data  = stageData[STAGES-1];

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stallCount;

    // Saturates rather than wrapping so long stalls never read as short ones.
    always_ff @(negedge clock) begin
        if (reset) begin
            stallCount <= 16'h0000;
        end else if (enable && (|stall) && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'h0001;
        end
    end

    assign stall_cycles = stallCount;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_regwall_chain.sv
// Self-checking bench for pipe_regwall_chain (STAGES=4, DATA_W=32) with a payload scoreboard.
// Honours PIPE_STALL_CNT_EN for the expected stall counter values.
module tb_pipe_regwall_chain;

    localparam int DW = 32;
    localparam int ST = 4;
`ifdef PIPE_STALL_CNT_EN
    localparam int CNT3 = 3;
`else
    localparam int CNT3 = 0;
`endif

    localparam logic [DW-1:0] VA = 32'hA1A1A1A1;
    localparam logic [DW-1:0] VB = 32'hB2B2B2B2;
    localparam logic [DW-1:0] VC = 32'hC3C3C3C3;
    localparam logic [DW-1:0] VD = 32'hD4D4D4D4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [ST-1:0]     stall;
    logic [ST-1:0]     flush;
    logic [ST-1:0]     tap_valid;
    logic [ST*DW-1:0]  tap_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [15:0]       stall_cycles;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sbQ[$];

    pipe_regwall_chain #(.DATA_W(DW), .STAGES(ST)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .tap_valid(tap_valid), .tap_data(tap_data),
        .out_valid(out_valid), .out_data(out_data),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // The DUT updates on the falling edge; sample 1ns later.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0] seq [4];
        seq[0] = d; seq[1] = c; seq[2] = b; seq[3] = a;
        enable = 1'b1; stall = '0; flush = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = seq[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        stall = '0; flush = '0;
        tick();
        tick();
        reset = 1'b0; in_valid = 1'b0; in_data = '0;
        checks++;
        if (tap_valid !== 4'b0000) begin
            failures++; $display("[TB] FAIL reset_valid actual=%b required=0000", tap_valid);
        end
        checks++;
        if (tap_data !== '0) begin
            failures++; $display("[TB] FAIL reset_data actual=%h required=0", tap_data);
        end
        checks++;
        if (stall_cycles !== 16'h0000) begin
            failures++; $display("[TB] FAIL reset_cnt actual=%h required=0000", stall_cycles);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ready actual=%b required=1", in_ready);
        end
    endtask

    task automatic test_flow();
        logic [DW-1:0] vals [3];
        int outCount = 0;
        int firstEdge = -1;
        logic [DW-1:0] expD;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        sbQ.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 3) begin
                in_valid = 1'b1; in_data = vals[cyc];
                sbQ.push_back(vals[cyc]);
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            tick();
            if (out_valid === 1'b1) begin
                outCount++;
                if (firstEdge < 0) firstEdge = cyc + 1;
                checks++;
                if (sbQ.size() == 0) begin
                    failures++; $display("[TB] FAIL flow_extra actual=%h required=none", out_data);
                end else begin
                    expD = sbQ.pop_front();
                    if (out_data !== expD) begin
                        failures++; $display("[TB] FAIL flow_data actual=%h required=%h", out_data, expD);
                    end
                end
            end
        end
        checks++;
        if (outCount != 3) begin
            failures++; $display("[TB] FAIL flow_count actual=%0d required=3", outCount);
        end
        checks++;
        if (firstEdge != 4) begin
            failures++; $display("[TB] FAIL flow_latency actual=%0d required=4", firstEdge);
        end
    endtask

    task automatic test_stall_insert();
        fill(VA, VB, VC, VD);
        stall = 4'b0010; in_valid = 1'b1; in_data = 32'hEEEE_EEEE;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_ready actual=%b required=0", in_ready);
        end
        tick();
        checks++;
        if (tap_valid !== 4'b1011) begin
            failures++; $display("[TB] FAIL stall_valid actual=%b required=1011", tap_valid);
        end
        checks++;
        if (tap_data !== {VC, 32'h0, VB, VA}) begin
            failures++; $display("[TB] FAIL stall_data actual=%h required=%h", tap_data, {VC, 32'h0, VB, VA});
        end
        stall = '0; in_valid = 1'b0; in_data = '0;
    endtask

    task automatic test_stall_flush();
        fill(VA, VB, VC, VD);
        stall = 4'b0001; flush = 4'b0011;
        tick();
        checks++;
        if (tap_valid !== 4'b1101) begin
            failures++; $display("[TB] FAIL stflush_valid actual=%b required=1101", tap_valid);
        end
        checks++;
        if (tap_data !== {VC, VB, 32'h0, VA}) begin
            failures++; $display("[TB] FAIL stflush_data actual=%h required=%h", tap_data, {VC, VB, 32'h0, VA});
        end
        stall = '0; flush = '0;
    endtask

    task automatic test_full_stall();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fill(VA, VB, VC, VD);
        stall = 4'b1000; in_valid = 1'b1; in_data = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tap_valid !== 4'b1111 || tap_data !== {VD, VC, VB, VA}) begin
                failures++; $display("[TB] FAIL fullstall_edge%0d actual=%b/%h required=1111/%h",
                                     i, tap_valid, tap_data, {VD, VC, VB, VA});
            end
        end
        checks++;
        if (stall_cycles !== 16'(CNT3)) begin
            failures++; $display("[TB] FAIL fullstall_cnt actual=%0d required=%0d", stall_cycles, CNT3);
        end
        stall = '0; in_valid = 1'b0; in_data = '0;
    endtask

    task automatic test_enable_reset();
        fill(VA, VB, VC, VD);
        enable = 1'b0; flush = 4'b1111; stall = 4'b0001; in_valid = 1'b1; in_data = 32'h9999_9999;
        tick();
        checks++;
        if (tap_valid !== 4'b1111 || tap_data !== {VD, VC, VB, VA}) begin
            failures++; $display("[TB] FAIL disabled_hold actual=%b/%h required=1111/%h",
                                 tap_valid, tap_data, {VD, VC, VB, VA});
        end
        checks++;
        if (stall_cycles !== 16'(CNT3)) begin
            failures++; $display("[TB] FAIL disabled_cnt actual=%0d required=%0d", stall_cycles, CNT3);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tap_valid !== 4'b0000 || tap_data !== '0 || stall_cycles !== 16'h0) begin
            failures++; $display("[TB] FAIL reset_disabled actual=%b/%h/%h required=0000/0/0",
                                 tap_valid, tap_data, stall_cycles);
        end
        reset = 1'b0; enable = 1'b1; flush = '0; stall = '0; in_valid = 1'b0; in_data = '0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] expD;
        int drain = 0;
        sbQ.delete();
        for (int cyc = 0; cyc < 32; cyc++) begin
            if (cyc < 24) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_data  = in_valid ? $urandom : '0;
                if (in_valid) sbQ.push_back(in_data);
            end else begin
                in_valid = 1'b0; in_data = '0;
            end
            tick();
            checks++;
            if (out_valid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    failures++; $display("[TB] FAIL b2b_extra actual=%h required=none", out_data);
                end else begin
                    expD = sbQ.pop_front();
                    if (out_data !== expD) begin
                        failures++; $display("[TB] FAIL b2b_data actual=%h required=%h", out_data, expD);
                    end
                end
            end else if (out_data !== '0) begin
                failures++; $display("[TB] FAIL b2b_bubble actual=%h required=0", out_data);
            end
            drain = cyc;
        end
        checks++;
        if (sbQ.size() != 0) begin
            failures++; $display("[TB] FAIL b2b_leftover actual=%0d required=0 after=%0d", sbQ.size(), drain);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 4'b1000; enable = 1'b1;
`ifdef PIPE_STALL_CNT_EN
        repeat (65534) tick();
        checks++;
        if (stall_cycles !== 16'hFFFE) begin
            failures++; $display("[TB] FAIL sat_pre actual=%h required=fffe", stall_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (stall_cycles !== 16'hFFFF) begin
                failures++; $display("[TB] FAIL sat_edge%0d actual=%h required=ffff", i, stall_cycles);
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (stall_cycles !== 16'h0000) begin
                failures++; $display("[TB] FAIL nocnt_edge%0d actual=%h required=0000", i, stall_cycles);
            end
        end
`endif
        stall = '0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        stall = '0; flush = '0;
        test_reset();
        test_flow();
        test_stall_insert();
        test_stall_flush();
        test_full_stall();
        test_enable_reset();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
